// File: rtl/cv32e40p_rf_recovery_unit_if.sv
// Register-file side bus of the recovery unit: core write-port snoop, recover write
// ports and backup read ports, bundled as one connection between the unit and the core.
interface cv32e40p_rf_recovery_unit_if;

   logic        snoop_we_a_i;
   logic [5:0]  snoop_waddr_a_i;
   logic [31:0] snoop_wdata_a_i;
   logic        snoop_we_b_i;
   logic [5:0]  snoop_waddr_b_i;
   logic [31:0] snoop_wdata_b_i;

   logic        recover_o;
   logic        regfile_we_a_o;
   logic [5:0]  regfile_waddr_a_o;
   logic [31:0] regfile_wdata_a_o;
   logic        regfile_we_b_o;
   logic [5:0]  regfile_waddr_b_o;
   logic [31:0] regfile_wdata_b_o;

   logic        regfile_backup_o;
   logic [5:0]  regfile_raddr_ra_o;
   logic [5:0]  regfile_raddr_rb_o;
   logic [5:0]  regfile_raddr_rc_o;
   logic [31:0] regfile_rdata_ra_i;
   logic [31:0] regfile_rdata_rb_i;
   logic [31:0] regfile_rdata_rc_i;

   // Recovery unit side
   modport master (
      input  snoop_we_a_i, snoop_waddr_a_i, snoop_wdata_a_i,
      input  snoop_we_b_i, snoop_waddr_b_i, snoop_wdata_b_i,
      output recover_o,
      output regfile_we_a_o, regfile_waddr_a_o, regfile_wdata_a_o,
      output regfile_we_b_o, regfile_waddr_b_o, regfile_wdata_b_o,
      output regfile_backup_o,
      output regfile_raddr_ra_o, regfile_raddr_rb_o, regfile_raddr_rc_o,
      input  regfile_rdata_ra_i, regfile_rdata_rb_i, regfile_rdata_rc_i
   );

   // Core side
   modport slave (
      output snoop_we_a_i, snoop_waddr_a_i, snoop_wdata_a_i,
      output snoop_we_b_i, snoop_waddr_b_i, snoop_wdata_b_i,
      input  recover_o,
      input  regfile_we_a_o, regfile_waddr_a_o, regfile_wdata_a_o,
      input  regfile_we_b_o, regfile_waddr_b_o, regfile_wdata_b_o,
      input  regfile_backup_o,
      input  regfile_raddr_ra_o, regfile_raddr_rb_o, regfile_raddr_rc_o,
      output regfile_rdata_ra_i, regfile_rdata_rb_i, regfile_rdata_rc_i
   );

endinterface

// File: rtl/cv32e40p_rf_recovery_unit.sv
// Shadow copy of the core register file: tracks core RF writes, can be seeded from the
// backup read ports (SYNC) and written back into the core RF (RESTORE).
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | snoop core RF writes, wait for sync/recovery request
// SYNC    | 3 RF entries per cycle copied via backup read ports, snoop active
// RESTORE | 2 shadow entries per cycle written back, core held, snoop off
// DONE    | one-cycle done pulse, then back to IDLE
module cv32e40p_rf_recovery_unit #(
   parameter int unsigned FPU        = 0,
   parameter int unsigned PULP_ZFINX = 0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sync_req_i,
   input  logic recovery_req_i,
   output logic busy_o,
   output logic done_o,
   cv32e40p_rf_recovery_unit_if.master rf_bus
);

   localparam int unsigned NUM_REGS      = (FPU != 0 && PULP_ZFINX == 0) ? 64 : 32;
   localparam int unsigned IDX_W         = $clog2(NUM_REGS);
   localparam int unsigned SYNC_STEPS    = (NUM_REGS + 2) / 3;
   localparam int unsigned RESTORE_STEPS = NUM_REGS / 2;

   localparam logic [5:0] SYNC_LAST    = 6'(SYNC_STEPS - 1);
   localparam logic [5:0] RESTORE_LAST = 6'(RESTORE_STEPS - 1);
   localparam logic [7:0] NUM_REGS_8   = 8'(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      RESTORE = 2'd2,
      DONE    = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] shadow_q [NUM_REGS];
   logic [31:0] shadow_d [NUM_REGS];

   logic [7:0]       sync_addr_ra, sync_addr_rb, sync_addr_rc;
   logic [7:0]       snoop_addr_a, snoop_addr_b;
   logic [IDX_W-1:0] rst_idx_a, rst_idx_b;
   logic             snoop_en;

   // Addresses are widened to 8 bits so the last SYNC step (past NUM_REGS) and
   // out-of-range snoop addresses can be rejected without wrapping into valid entries.
   always_comb begin
      sync_addr_ra = {2'b00, cnt_q} * 8'd3;
      sync_addr_rb = sync_addr_ra + 8'd1;
      sync_addr_rc = sync_addr_ra + 8'd2;
      snoop_addr_a = {2'b00, rf_bus.snoop_waddr_a_i};
      snoop_addr_b = {2'b00, rf_bus.snoop_waddr_b_i};
      rst_idx_a    = IDX_W'({cnt_q, 1'b0});
      rst_idx_b    = IDX_W'({cnt_q, 1'b1});
      snoop_en     = (state_q == IDLE) || (state_q == SYNC);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (recovery_req_i) begin
               state_d = RESTORE;
            end else if (sync_req_i) begin
               state_d = SYNC;
            end
         end
         SYNC: begin
            if (cnt_q == SYNC_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         RESTORE: begin
            if (cnt_q == RESTORE_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      busy_o                    = (state_q != IDLE);
      done_o                    = 1'b0;
      rf_bus.recover_o          = 1'b0;
      rf_bus.regfile_we_a_o     = 1'b0;
      rf_bus.regfile_waddr_a_o  = '0;
      rf_bus.regfile_wdata_a_o  = '0;
      rf_bus.regfile_we_b_o     = 1'b0;
      rf_bus.regfile_waddr_b_o  = '0;
      rf_bus.regfile_wdata_b_o  = '0;
      rf_bus.regfile_backup_o   = 1'b0;
      rf_bus.regfile_raddr_ra_o = '0;
      rf_bus.regfile_raddr_rb_o = '0;
      rf_bus.regfile_raddr_rc_o = '0;
      unique case (state_q)
         SYNC: begin
            rf_bus.regfile_backup_o   = 1'b1;
            rf_bus.regfile_raddr_ra_o = sync_addr_ra[5:0];
            rf_bus.regfile_raddr_rb_o = sync_addr_rb[5:0];
            rf_bus.regfile_raddr_rc_o = sync_addr_rc[5:0];
         end
         RESTORE: begin
            rf_bus.recover_o         = 1'b1;
            rf_bus.regfile_we_a_o    = 1'b1;
            rf_bus.regfile_waddr_a_o = 6'({cnt_q, 1'b0});
            rf_bus.regfile_wdata_a_o = shadow_q[rst_idx_a];
            rf_bus.regfile_we_b_o    = 1'b1;
            rf_bus.regfile_waddr_b_o = 6'({cnt_q, 1'b1});
            rf_bus.regfile_wdata_b_o = shadow_q[rst_idx_b];
         end
         DONE: begin
            done_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Priority, lowest first: backup capture, snoop port A, snoop port B.
   always_comb begin
      shadow_d = shadow_q;
      if (state_q == SYNC) begin
         if (sync_addr_ra < NUM_REGS_8) shadow_d[IDX_W'(sync_addr_ra)] = rf_bus.regfile_rdata_ra_i;
         if (sync_addr_rb < NUM_REGS_8) shadow_d[IDX_W'(sync_addr_rb)] = rf_bus.regfile_rdata_rb_i;
         if (sync_addr_rc < NUM_REGS_8) shadow_d[IDX_W'(sync_addr_rc)] = rf_bus.regfile_rdata_rc_i;
      end
      if (snoop_en) begin
         if (rf_bus.snoop_we_a_i && (snoop_addr_a < NUM_REGS_8)) begin
            shadow_d[IDX_W'(snoop_addr_a)] = rf_bus.snoop_wdata_a_i;
         end
         if (rf_bus.snoop_we_b_i && (snoop_addr_b < NUM_REGS_8)) begin
            shadow_d[IDX_W'(snoop_addr_b)] = rf_bus.snoop_wdata_b_i;
         end
      end
      shadow_d[0] = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         shadow_q <= shadow_d;
      end
   end

endmodule

// File: tb/tb_cv32e40p_rf_recovery_unit.sv
// Directed bench for the RF recovery unit: a 32-entry instance for snoop/sync/restore
// behaviour and a 64-entry (FPU) instance for the long restore and mid-restore reset.
module tb_cv32e40p_rf_recovery_unit;

   logic clk;
   logic rst_n0, rst_n1;
   logic sync_req, recovery_req;
   logic sel;
   logic busy0, done0, busy1, done1;

   logic        s_we_a, s_we_b;
   logic [5:0]  s_aa, s_ab;
   logic [31:0] s_da, s_db;

   cv32e40p_rf_recovery_unit_if if0 ();
   cv32e40p_rf_recovery_unit_if if1 ();

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_rd(input logic [5:0] a);
      return (a < 6'd32) ? (32'h100 + {26'b0, a}) : (32'hBAD0_0000 | {26'b0, a});
   endfunction

   assign if0.snoop_we_a_i    = s_we_a;
   assign if0.snoop_waddr_a_i = s_aa;
   assign if0.snoop_wdata_a_i = s_da;
   assign if0.snoop_we_b_i    = s_we_b;
   assign if0.snoop_waddr_b_i = s_ab;
   assign if0.snoop_wdata_b_i = s_db;
   assign if0.regfile_rdata_ra_i = model_rd(if0.regfile_raddr_ra_o);
   assign if0.regfile_rdata_rb_i = model_rd(if0.regfile_raddr_rb_o);
   assign if0.regfile_rdata_rc_i = model_rd(if0.regfile_raddr_rc_o);

   assign if1.snoop_we_a_i    = s_we_a;
   assign if1.snoop_waddr_a_i = s_aa;
   assign if1.snoop_wdata_a_i = s_da;
   assign if1.snoop_we_b_i    = s_we_b;
   assign if1.snoop_waddr_b_i = s_ab;
   assign if1.snoop_wdata_b_i = s_db;
   assign if1.regfile_rdata_ra_i = model_rd(if1.regfile_raddr_ra_o);
   assign if1.regfile_rdata_rb_i = model_rd(if1.regfile_raddr_rb_o);
   assign if1.regfile_rdata_rc_i = model_rd(if1.regfile_raddr_rc_o);

   cv32e40p_rf_recovery_unit #(.FPU(0), .PULP_ZFINX(0)) dut0 (
      .clk_i          (clk),
      .rst_ni         (rst_n0),
      .sync_req_i     (sync_req & ~sel),
      .recovery_req_i (recovery_req & ~sel),
      .busy_o         (busy0),
      .done_o         (done0),
      .rf_bus         (if0)
   );

   cv32e40p_rf_recovery_unit #(.FPU(1), .PULP_ZFINX(0)) dut1 (
      .clk_i          (clk),
      .rst_ni         (rst_n1),
      .sync_req_i     (sync_req & sel),
      .recovery_req_i (recovery_req & sel),
      .busy_o         (busy1),
      .done_o         (done1),
      .rf_bus         (if1)
   );

   logic        o_busy, o_done, o_rec, o_bak, o_wea, o_web;
   logic [5:0]  o_waa, o_wab, o_ra, o_rb, o_rc;
   logic [31:0] o_wda, o_wdb;

   always_comb begin
      o_busy = sel ? busy1 : busy0;
      o_done = sel ? done1 : done0;
      o_rec  = sel ? if1.recover_o : if0.recover_o;
      o_bak  = sel ? if1.regfile_backup_o : if0.regfile_backup_o;
      o_wea  = sel ? if1.regfile_we_a_o : if0.regfile_we_a_o;
      o_web  = sel ? if1.regfile_we_b_o : if0.regfile_we_b_o;
      o_waa  = sel ? if1.regfile_waddr_a_o : if0.regfile_waddr_a_o;
      o_wab  = sel ? if1.regfile_waddr_b_o : if0.regfile_waddr_b_o;
      o_wda  = sel ? if1.regfile_wdata_a_o : if0.regfile_wdata_a_o;
      o_wdb  = sel ? if1.regfile_wdata_b_o : if0.regfile_wdata_b_o;
      o_ra   = sel ? if1.regfile_raddr_ra_o : if0.regfile_raddr_ra_o;
      o_rb   = sel ? if1.regfile_raddr_rb_o : if0.regfile_raddr_rb_o;
      o_rc   = sel ? if1.regfile_raddr_rc_o : if0.regfile_raddr_rc_o;
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] img [64];

   typedef struct {
      logic        we_a;
      logic [5:0]  aa;
      logic [31:0] da;
      logic        we_b;
      logic [5:0]  ab;
      logic [31:0] db;
      int          chk_addr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic snoop(input logic wa, input logic [5:0] aa, input logic [31:0] da,
                        input logic wb, input logic [5:0] ab, input logic [31:0] db);
      s_we_a = wa; s_aa = aa; s_da = da;
      s_we_b = wb; s_ab = ab; s_db = db;
      step();
      s_we_a = 1'b0; s_we_b = 1'b0;
   endtask

   // Full restore; captures the written-back image into img[].
   task automatic do_restore(input int nregs, input int inj_k, input logic [5:0] inj_a,
                             input logic [31:0] inj_d, input logic with_sync);
      recovery_req = 1'b1;
      sync_req     = with_sync;
      step();
      recovery_req = 1'b0;
      sync_req     = 1'b0;
      for (int k = 0; k < nregs / 2; k++) begin
         chk("restore_ctl", {o_busy, o_done, o_rec, o_bak, o_wea, o_web, o_waa, o_wab},
             {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'(2 * k), 6'(2 * k + 1)});
         img[2 * k]     = o_wda;
         img[2 * k + 1] = o_wdb;
         if (k == inj_k) begin
            s_we_a = 1'b1; s_aa = inj_a; s_da = inj_d;
         end
         step();
         s_we_a = 1'b0;
      end
      chk("restore_done", {o_busy, o_done, o_rec, o_wea, o_web}, 5'b11000);
      step();
      chk("restore_idle", {o_busy, o_done, o_rec, o_wea, o_web}, 5'b00000);
   endtask

   task automatic do_sync(input int inj_k, input logic inj_we, input logic [5:0] inj_a,
                          input logic [31:0] inj_d, input logic inj_rec);
      sync_req = 1'b1;
      step();
      sync_req = 1'b0;
      for (int k = 0; k < 11; k++) begin
         chk("sync_ctl", {o_busy, o_done, o_bak, o_rec, o_ra, o_rb, o_rc},
             {1'b1, 1'b0, 1'b1, 1'b0, 6'(3 * k), 6'(3 * k + 1), 6'(3 * k + 2)});
         if (k == inj_k) begin
            s_we_a = inj_we; s_aa = inj_a; s_da = inj_d;
            recovery_req = inj_rec;
         end
         step();
         s_we_a = 1'b0;
         recovery_req = 1'b0;
      end
      chk("sync_done", {o_busy, o_done, o_bak}, 3'b110);
      step();
      chk("sync_idle", {o_busy, o_done, o_bak}, 3'b000);
   endtask

   initial begin
      vecs[0] = '{1'b1, 6'd7,  32'h1,        1'b1, 6'd7,  32'h2,        7,  32'h2};
      vecs[1] = '{1'b1, 6'd0,  32'h1234,     1'b0, 6'd0,  32'h0,        0,  32'h0};
      vecs[2] = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd0,  32'h5678,     0,  32'h0};
      vecs[3] = '{1'b1, 6'd3,  32'hA5A5,     1'b1, 6'd9,  32'h5A5A,     3,  32'hA5A5};
      vecs[4] = '{1'b1, 6'd40, 32'hFFFF,     1'b0, 6'd0,  32'h0,        8,  32'h108};
      vecs[5] = '{1'b0, 6'd11, 32'hFFFF,     1'b0, 6'd11, 32'hEEEE,     11, 32'h10B};
      vecs[6] = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd31, 32'h31313131, 31, 32'h31313131};
      vecs[7] = '{1'b1, 6'd9,  32'h99,       1'b0, 6'd9,  32'h77,       9,  32'h99};
      vecs[8] = '{1'b1, 6'd12, 32'hAAAA,     1'b1, 6'd13, 32'hBBBB,     13, 32'hBBBB};

      sel = 1'b0; sync_req = 1'b0; recovery_req = 1'b0;
      s_we_a = 1'b0; s_we_b = 1'b0; s_aa = '0; s_ab = '0; s_da = '0; s_db = '0;
      rst_n0 = 1'b1; rst_n1 = 1'b1;
      #3;
      rst_n0 = 1'b0; rst_n1 = 1'b0;
      step();
      step();
      chk("reset_ctl", {o_busy, o_done, o_rec, o_bak, o_wea, o_web}, 6'b0);
      chk("reset_addr", {o_waa, o_wab, o_ra, o_rb, o_rc}, 30'b0);
      chk("reset_data", {o_wda, o_wdb}, 64'b0);
      rst_n0 = 1'b1; rst_n1 = 1'b1;
      step();

      // Single snoop then restore
      snoop(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'h0);
      do_restore(32, -1, 6'd0, 32'h0, 1'b0);
      chk("t1_x5", img[5], 32'hDEADBEEF);
      chk("t1_x0", img[0], 32'h0);
      chk("t1_x6", img[6], 32'h0);
      chk("t1_x31", img[31], 32'h0);

      // Sync from model RF, then restore the copied image
      do_sync(-1, 1'b0, 6'd0, 32'h0, 1'b0);
      do_restore(32, -1, 6'd0, 32'h0, 1'b0);
      chk("t2_x0", img[0], 32'h0);
      for (int i = 1; i < 32; i++) begin
         chk("t2_xi", img[i], 32'h100 + 32'(i));
      end

      for (int v = 0; v < 9; v++) begin
         snoop(vecs[v].we_a, vecs[v].aa, vecs[v].da, vecs[v].we_b, vecs[v].ab, vecs[v].db);
         do_restore(32, -1, 6'd0, 32'h0, 1'b0);
         chk("vec", img[vecs[v].chk_addr], vecs[v].exp);
      end

      // Snoop beats backup data during SYNC; snoop ignored during RESTORE
      do_sync(3, 1'b1, 6'd10, 32'hCAFE, 1'b0);
      do_restore(32, -1, 6'd0, 32'h0, 1'b0);
      chk("t4_x10", img[10], 32'hCAFE);
      chk("t4_x9", img[9], 32'h109);
      chk("t4_x11", img[11], 32'h10B);
      do_restore(32, 3, 6'd4, 32'h55, 1'b0);
      do_restore(32, -1, 6'd0, 32'h0, 1'b0);
      chk("t4_x4", img[4], 32'h104);

      // Request priority and requests dropped while busy
      do_restore(32, -1, 6'd0, 32'h0, 1'b1);
      do_sync(5, 1'b0, 6'd0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_no_restart", {o_busy, o_done, o_rec}, 3'b000);
      end

      // FPU instance: 64-entry restore and async reset mid-restore
      sel = 1'b1;
      rst_n1 = 1'b0;
      step();
      rst_n1 = 1'b1;
      step();
      snoop(1'b1, 6'd63, 32'h63636363, 1'b1, 6'd33, 32'h33333333);
      do_restore(64, -1, 6'd0, 32'h0, 1'b0);
      chk("t6_x63", img[63], 32'h63636363);
      chk("t6_x33", img[33], 32'h33333333);
      chk("t6_x62", img[62], 32'h0);

      recovery_req = 1'b1;
      step();
      recovery_req = 1'b0;
      for (int k = 0; k < 10; k++) step();
      chk("t6_pre_abort", {o_busy, o_rec, o_waa}, {1'b1, 1'b1, 6'd20});
      rst_n1 = 1'b0;
      #1;
      chk("t6_abort", {o_busy, o_done, o_rec, o_wea, o_web}, 5'b00000);
      step();
      step();
      rst_n1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_no_done", {o_busy, o_done, o_rec}, 3'b000);
      end
      do_restore(64, -1, 6'd0, 32'h0, 1'b0);
      chk("t6_cleared63", img[63], 32'h0);
      chk("t6_cleared33", img[33], 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
